axi_sram_slave: RTL and testbench

//  AXI4 slave SRAM model answering the core's AXI master port (io_master_* of the CPU bus interface).

---
 rtl/axi_pkg.sv | 33 +++
 rtl/axi_delay_lfsr.sv | 52 +++++
 rtl/axi_sram_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state types and LFSR helper
// for the SRAM slave model.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_DATA,
    W_RESP
  } wstate_e;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/axi_delay_lfsr.sv
// Free-running LFSR plus one delay down-counter per channel;
// both channels sample the same delay source at accept.
module axi_delay_lfsr
  import axi_pkg::*;
#(
  parameter int LATENCY    = 0,
  parameter bit RAND_DELAY = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rd_load,
  input  logic i_wr_load,
  output logic o_delay_zero,
  output logic o_rd_expire,
  output logic o_wr_expire
);

  logic [15:0] r_lfsr;
  logic [7:0]  r_rcnt;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_delay;

  assign w_delay = RAND_DELAY ? {4'd0, r_lfsr[3:0]}
                              : 8'(LATENCY);

  assign o_delay_zero = (w_delay == 8'd0);
  // expire one cycle early so data shows up after exactly
  // w_delay waiting cycles
  assign o_rd_expire  = (r_rcnt == 8'd1);
  assign o_wr_expire  = (r_wcnt == 8'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= LFSR_SEED;
      r_rcnt <= 8'd0;
      r_wcnt <= 8'd0;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      if (i_rd_load) begin
        r_rcnt <= w_delay;
      end else if (r_rcnt != 8'd0) begin
        r_rcnt <= r_rcnt - 8'd1;
      end
      if (i_wr_load) begin
        r_wcnt <= w_delay;
      end else if (r_wcnt != 8'd0) begin
        r_wcnt <= r_wcnt - 8'd1;
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM slave model with fixed or LFSR-random latency
// on independent read and write channels.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH      = 4096,
  parameter int          LATENCY    = 0,
  parameter bit          RAND_DELAY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH) << 2;

  logic [31:0] r_mem [DEPTH];

  rstate_e     r_rstate;
  rstate_e     w_rnext;
  wstate_e     r_wstate;
  wstate_e     w_wnext;
  logic [31:0] r_raddr;
  logic [31:0] r_waddr;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rbeat;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wbeat;
  logic [3:0]  r_rid;
  logic [3:0]  r_bid;
  logic        r_decerr;
  logic        r_slverr;

  logic        w_ar_fire;
  logic        w_r_fire;
  logic        w_aw_fire;
  logic        w_w_fire;
  logic        w_zero;
  logic        w_rd_expire;
  logic        w_wr_expire;
  logic        w_rlast;
  logic        w_wlast;
  logic [31:0] w_roff;
  logic [31:0] w_woff;
  logic        w_rin;
  logic        w_win;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_widx;
  logic        w_unused;

  assign w_ar_fire = io_slave_arvalid & io_slave_arready;
  assign w_r_fire  = io_slave_rvalid & io_slave_rready;
  assign w_aw_fire = io_slave_awvalid & io_slave_awready;
  assign w_w_fire  = io_slave_wvalid & io_slave_wready;

  assign w_rlast = (r_rbeat == r_rlen);
  assign w_wlast = (r_wbeat == r_wlen);

  // unsigned wrap makes addresses below BASE fail the bound too
  assign w_roff = r_raddr - BASE_ADDR;
  assign w_woff = r_waddr - BASE_ADDR;
  assign w_rin  = (w_roff < MEM_BYTES);
  assign w_win  = (w_woff < MEM_BYTES);
  assign w_ridx = w_roff[AW+1:2];
  assign w_widx = w_woff[AW+1:2];

  assign w_unused = ^{io_slave_awsize, io_slave_arsize,
                      io_slave_awburst == BURST_INCR,
                      io_slave_arburst == BURST_INCR,
                      w_roff[31:AW+2], w_roff[1:0],
                      w_woff[31:AW+2], w_woff[1:0]};

  axi_delay_lfsr #(
    .LATENCY    (LATENCY),
    .RAND_DELAY (RAND_DELAY)
  ) u_delay (
    .i_clk        (clock),
    .i_rst_n      (reset),
    .i_rd_load    (w_ar_fire),
    .i_wr_load    (w_aw_fire),
    .o_delay_zero (w_zero),
    .o_rd_expire  (w_rd_expire),
    .o_wr_expire  (w_wr_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rnext;
      r_wstate <= w_wnext;
    end
  end

  always_comb begin
    w_rnext          = r_rstate;
    io_slave_arready = 1'b0;
    io_slave_rvalid  = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        io_slave_arready = reset;
        if (io_slave_arvalid && reset) begin
          w_rnext = w_zero ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        if (w_rd_expire) w_rnext = R_DATA;
      end
      R_DATA: begin
        io_slave_rvalid = 1'b1;
        if (io_slave_rready && w_rlast) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  always_comb begin
    w_wnext          = r_wstate;
    io_slave_awready = 1'b0;
    io_slave_wready  = 1'b0;
    io_slave_bvalid  = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        io_slave_awready = reset;
        if (io_slave_awvalid && reset) begin
          w_wnext = w_zero ? W_DATA : W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_wr_expire) w_wnext = W_DATA;
      end
      W_DATA: begin
        io_slave_wready = 1'b1;
        if (io_slave_wvalid && w_wlast) w_wnext = W_RESP;
      end
      W_RESP: begin
        io_slave_bvalid = 1'b1;
        if (io_slave_bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_raddr <= '0;
      r_rlen  <= '0;
      r_rbeat <= '0;
      r_rid   <= '0;
    end else if (w_ar_fire) begin
      r_raddr <= io_slave_araddr;
      r_rlen  <= io_slave_arlen;
      r_rbeat <= '0;
      r_rid   <= io_slave_arid;
    end else if (w_r_fire) begin
      r_raddr <= r_raddr + 32'd4;
      r_rbeat <= r_rbeat + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wbeat  <= '0;
      r_bid    <= '0;
      r_decerr <= 1'b0;
      r_slverr <= 1'b0;
    end else if (w_aw_fire) begin
      r_waddr  <= io_slave_awaddr;
      r_wlen   <= io_slave_awlen;
      r_wbeat  <= '0;
      r_bid    <= io_slave_awid;
      r_decerr <= 1'b0;
      r_slverr <= 1'b0;
    end else if (w_w_fire) begin
      r_waddr <= r_waddr + 32'd4;
      r_wbeat <= r_wbeat + 8'd1;
      if (!w_win) r_decerr <= 1'b1;
      if (io_slave_wlast != w_wlast) r_slverr <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_w_fire && w_win) begin
      for (int i = 0; i < 4; i++) begin
        if (io_slave_wstrb[i]) begin
          r_mem[w_widx][8*i +: 8] <= io_slave_wdata[8*i +: 8];
        end
      end
    end
  end

  assign io_slave_rdata = (io_slave_rvalid && w_rin) ? r_mem[w_ridx] : '0;
  assign io_slave_rresp = (io_slave_rvalid && !w_rin) ? RESP_DECERR
                                                      : RESP_OKAY;
  assign io_slave_rlast = io_slave_rvalid & w_rlast;
  assign io_slave_rid   = r_rid;

  assign io_slave_bresp = !io_slave_bvalid ? RESP_OKAY   :
                          r_decerr         ? RESP_DECERR :
                          r_slverr         ? RESP_SLVERR :
                                             RESP_OKAY;
  assign io_slave_bid   = r_bid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed and random checks for axi_sram_slave on three
// instances: zero latency, fixed latency 3, random latency.
module tb_axi_sram_slave;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        awvalid = 1'b0;
  logic [31:0] awaddr  = '0;
  logic [3:0]  awid    = '0;
  logic [7:0]  awlen   = '0;
  logic [2:0]  awsize  = 3'd2;
  logic [1:0]  awburst = 2'b01;
  logic        wvalid  = 1'b0;
  logic [31:0] wdata   = '0;
  logic [3:0]  wstrb   = '0;
  logic        wlast   = 1'b0;
  logic        bready  = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr  = '0;
  logic [3:0]  arid    = '0;
  logic [7:0]  arlen   = '0;
  logic [2:0]  arsize  = 3'd2;
  logic [1:0]  arburst = 2'b01;
  logic        rready  = 1'b0;

  logic        a_awready [3];
  logic        a_wready  [3];
  logic        a_bvalid  [3];
  logic [1:0]  a_bresp   [3];
  logic [3:0]  a_bid     [3];
  logic        a_arready [3];
  logic        a_rvalid  [3];
  logic [31:0] a_rdata   [3];
  logic [1:0]  a_rresp   [3];
  logic        a_rlast   [3];
  logic [3:0]  a_rid     [3];

  int sel = 0;
  int n_chk = 0;
  int n_fail = 0;

  wire        awready = a_awready[sel];
  wire        wready  = a_wready[sel];
  wire        bvalid  = a_bvalid[sel];
  wire [1:0]  bresp   = a_bresp[sel];
  wire [3:0]  bid     = a_bid[sel];
  wire        arready = a_arready[sel];
  wire        rvalid  = a_rvalid[sel];
  wire [31:0] rdata   = a_rdata[sel];
  wire [1:0]  rresp   = a_rresp[sel];
  wire        rlast   = a_rlast[sel];
  wire [3:0]  rid     = a_rid[sel];

  logic [31:0] wr_buf [256];
  logic [31:0] rd_buf [256];
  logic [1:0]  rd_rsp [256];
  logic        rd_lst [256];
  logic [3:0]  rd_id;
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axi_sram_slave #(
      .BASE_ADDR  (32'h8000_0000),
      .DEPTH      (4096),
      .LATENCY    (g == 1 ? 3 : 0),
      .RAND_DELAY (g == 2)
    ) u_dut (
      .clock            (clk),
      .reset            (rst_n),
      .io_slave_awready (a_awready[g]),
      .io_slave_awvalid (awvalid),
      .io_slave_awaddr  (awaddr),
      .io_slave_awid    (awid),
      .io_slave_awlen   (awlen),
      .io_slave_awsize  (awsize),
      .io_slave_awburst (awburst),
      .io_slave_wready  (a_wready[g]),
      .io_slave_wvalid  (wvalid),
      .io_slave_wdata   (wdata),
      .io_slave_wstrb   (wstrb),
      .io_slave_wlast   (wlast),
      .io_slave_bready  (bready),
      .io_slave_bvalid  (a_bvalid[g]),
      .io_slave_bresp   (a_bresp[g]),
      .io_slave_bid     (a_bid[g]),
      .io_slave_arready (a_arready[g]),
      .io_slave_arvalid (arvalid),
      .io_slave_araddr  (araddr),
      .io_slave_arid    (arid),
      .io_slave_arlen   (arlen),
      .io_slave_arsize  (arsize),
      .io_slave_arburst (arburst),
      .io_slave_rready  (rready),
      .io_slave_rvalid  (a_rvalid[g]),
      .io_slave_rdata   (a_rdata[g]),
      .io_slave_rresp   (a_rresp[g]),
      .io_slave_rlast   (a_rlast[g]),
      .io_slave_rid     (a_rid[g])
    );
  end

  task automatic pulse_reset();
    @(negedge clk);
    awvalid = 0; wvalid = 0; bready = 0;
    arvalid = 0; rready = 0; wlast = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_write(
    input  logic [31:0] addr,
    input  logic [3:0]  id,
    input  logic [7:0]  len,
    input  logic [3:0]  strb,
    input  bit          bad_last,
    output logic [1:0]  resp,
    output logic [3:0]  rbid,
    output int          bwait
  );
    int n;
    int beat;
    @(negedge clk);
    awvalid = 1; awaddr = addr; awid = id; awlen = len;
    n = 0;
    while (!awready && n < 100) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    @(negedge clk);
    awvalid = 0;
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 600) begin
      wvalid = 1;
      wdata  = wr_buf[beat];
      wstrb  = strb;
      wlast  = bad_last ? (beat == 0) : (beat == int'(len));
      if (wready) beat++;
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= 600) begin
      n_fail++;
      $display("FAIL w_timeout: beats=%0d required %0d", beat, int'(len) + 1);
    end
    wvalid = 0; wlast = 0; bready = 1;
    n = 0;
    while (!bvalid && n < 100) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
    end
    resp = bresp; rbid = bid; bwait = n;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(
    input  logic [31:0] addr,
    input  logic [3:0]  id,
    input  logic [7:0]  len,
    input  int          mode,
    output int          lat
  );
    int n;
    int got;
    bit seen;
    bit held;
    logic [31:0] hdata;
    logic hlast;
    @(negedge clk);
    arvalid = 1; araddr = addr; arid = id; arlen = len;
    n = 0;
    while (!arready && n < 100) begin
      @(negedge clk); n++;
    end
    n_chk++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL ar_timeout: arready=%b required 1", arready);
    end
    @(negedge clk);
    arvalid = 0;
    lat = 1; got = 0; seen = 0; held = 0; n = 0;
    hdata = '0; hlast = 0;
    while (got <= int'(len) && n < 600) begin
      if (held) begin
        n_chk++;
        if (!rvalid || rdata !== hdata || rlast !== hlast) begin
          n_fail++;
          $display("FAIL r_stall: rvalid=%b rdata=%h rlast=%b required 1 %h %b",
                   rvalid, rdata, rlast, hdata, hlast);
        end
        held = 0;
      end
      case (mode)
        0: rready = 1;
        1: rready = (n % 2 == 0);
        default: rready = ($urandom_range(3, 0) != 0);
      endcase
      if (rvalid) begin
        seen = 1;
        if (rready) begin
          rd_buf[got] = rdata;
          rd_rsp[got] = rresp;
          rd_lst[got] = rlast;
          rd_id = rid;
          got++;
        end else begin
          held = 1; hdata = rdata; hlast = rlast;
        end
      end else if (!seen) begin
        lat++;
      end
      @(negedge clk); n++;
    end
    rready = 0;
    n_chk++;
    if (n >= 600) begin
      n_fail++;
      $display("FAIL r_timeout: beats=%0d required %0d", got, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_hs: aw w b ar r rl=%b required 000000",
               {awready, wready, bvalid, arready, rvalid, rlast});
    end
    n_chk++;
    if ({bresp, rresp, bid, rid, rdata} !== 44'b0) begin
      n_fail++;
      $display("FAIL reset_data: bresp=%b rresp=%b bid=%h rid=%h rdata=%h required 0",
               bresp, rresp, bid, rid, rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({arready, awready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: arready=%b awready=%b required 1 1",
               arready, awready);
    end
  endtask

  task automatic test_read_basic();
    logic [1:0] resp;
    logic [3:0] b;
    int bw;
    int lat;
    wr_buf[0] = 32'h0000_0413;
    do_write(32'h8000_0000, 4'd3, 8'd0, 4'hF, 0, resp, b, bw);
    n_chk++;
    if (resp !== 2'b00) begin
      n_fail++;
      $display("FAIL init_bresp: got %b required 00", resp);
    end
    do_read(32'h8000_0000, 4'd5, 8'd0, 0, lat);
    n_chk++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL rd_latency0: got %0d required 1", lat);
    end
    n_chk++;
    if (rd_buf[0] !== 32'h0000_0413 || rd_lst[0] !== 1'b1 ||
        rd_rsp[0] !== 2'b00 || rd_id !== 4'd5) begin
      n_fail++;
      $display("FAIL rd_basic: data=%h last=%b resp=%b id=%h required 00000413 1 00 5",
               rd_buf[0], rd_lst[0], rd_rsp[0], rd_id);
    end
    n_chk++;
    if (arready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_back_to_idle: arready=%b required 1", arready);
    end
  endtask

  task automatic test_write_strb();
    logic [1:0] resp;
    logic [3:0] b;
    int bw;
    int lat;
    wr_buf[0] = 32'h1122_3344;
    do_write(32'h8000_0010, 4'd1, 8'd0, 4'hF, 0, resp, b, bw);
    wr_buf[0] = 32'hDEAD_BEEF;
    do_write(32'h8000_0010, 4'd9, 8'd0, 4'b0011, 0, resp, b, bw);
    n_chk++;
    if (resp !== 2'b00 || b !== 4'd9 || bw !== 0) begin
      n_fail++;
      $display("FAIL wr_strb_b: resp=%b bid=%h wait=%0d required 00 9 0",
               resp, b, bw);
    end
    do_read(32'h8000_0010, 4'd2, 8'd0, 0, lat);
    n_chk++;
    if (rd_buf[0] !== 32'h1122_BEEF) begin
      n_fail++;
      $display("FAIL wr_strb_data: got %h required 1122beef", rd_buf[0]);
    end
  endtask

  task automatic test_errors();
    logic [1:0] resp;
    logic [3:0] b;
    int bw;
    int lat;
    wr_buf[0] = 32'h5555_5555;
    wr_buf[1] = 32'h6666_6666;
    do_write(32'h8000_0040, 4'd4, 8'd1, 4'hF, 1, resp, b, bw);
    n_chk++;
    if (resp !== 2'b10) begin
      n_fail++;
      $display("FAIL slverr: bresp=%b required 10", resp);
    end
    do_read(32'h7000_0000, 4'd6, 8'd0, 0, lat);
    n_chk++;
    if (rd_rsp[0] !== 2'b11 || rd_buf[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL rd_decerr: rresp=%b rdata=%h required 11 00000000",
               rd_rsp[0], rd_buf[0]);
    end
    wr_buf[0] = 32'hFFFF_FFFF;
    do_write(32'h9000_0000, 4'd7, 8'd0, 4'hF, 0, resp, b, bw);
    n_chk++;
    if (resp !== 2'b11) begin
      n_fail++;
      $display("FAIL wr_decerr: bresp=%b required 11", resp);
    end
    do_read(32'h8000_0000, 4'd0, 8'd0, 0, lat);
    n_chk++;
    if (rd_buf[0] !== 32'h0000_0413) begin
      n_fail++;
      $display("FAIL wr_decerr_mem: got %h required 00000413", rd_buf[0]);
    end
  endtask

  task automatic test_latency_burst();
    logic [1:0] resp;
    logic [3:0] b;
    int bw;
    int lat;
    for (int i = 0; i < 4; i++) wr_buf[i] = 32'hA0A0_0000 + 32'(i);
    do_write(32'h8000_0020, 4'd2, 8'd3, 4'hF, 0, resp, b, bw);
    n_chk++;
    if (resp !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_bresp: got %b required 00", resp);
    end
    do_read(32'h8000_0020, 4'd8, 8'd3, 1, lat);
    n_chk++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL rd_latency3: got %0d required 4", lat);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (rd_buf[i] !== 32'hA0A0_0000 + 32'(i) || rd_lst[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL burst_beat%0d: data=%h last=%b required %h %b",
                 i, rd_buf[i], rd_lst[i], 32'hA0A0_0000 + 32'(i), i == 3);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int n;
    pulse_reset();
    awvalid = 1; awaddr = 32'h8000_0100; awid = 4'd1; awlen = 8'd0;
    @(negedge clk);
    awvalid = 0;
    n = 0;
    while (!wready && n < 20) begin
      @(negedge clk); n++;
    end
    arvalid = 1; araddr = 32'h8000_0000; arid = 4'd2; arlen = 8'd0;
    @(negedge clk);
    arvalid = 0;
    n_chk++;
    if (wready !== 1'b1 || rvalid !== 1'b0 || arready !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_pre: wready=%b rvalid=%b arready=%b required 1 0 0",
               wready, rvalid, arready);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: aw w b ar r=%b required 00000",
               {awready, wready, bvalid, arready, rvalid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL inflight_release: ar aw w r b=%b required 11000",
               {arready, awready, wready, rvalid, bvalid});
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if ({rvalid, bvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL inflight_dropped: rvalid=%b bvalid=%b required 0 0",
               rvalid, bvalid);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp;
    logic [3:0] b;
    logic [3:0] st;
    int bw;
    int lat;
    int w;
    int l;
    for (int i = 0; i < 64; i++) begin
      wr_buf[i] = $urandom;
      ref_mem[i] = wr_buf[i];
    end
    do_write(32'h8000_0000, 4'd0, 8'd63, 4'hF, 0, resp, b, bw);
    for (int k = 0; k < 1000; k++) begin
      w = $urandom_range(60, 0);
      l = $urandom_range(3, 0);
      if ($urandom_range(1, 0) == 1) begin
        st = 4'($urandom_range(15, 1));
        for (int j = 0; j <= l; j++) begin
          wr_buf[j] = $urandom;
          for (int y = 0; y < 4; y++) begin
            if (st[y]) ref_mem[w+j][8*y +: 8] = wr_buf[j][8*y +: 8];
          end
        end
        do_write(32'h8000_0000 + 32'(w * 4), 4'(k), 8'(l), st, 0,
                 resp, b, bw);
        n_chk++;
        if (resp !== 2'b00 || b !== 4'(k)) begin
          n_fail++;
          $display("FAIL rnd_store%0d: bresp=%b bid=%h required 00 %h",
                   k, resp, b, 4'(k));
        end
      end else begin
        do_read(32'h8000_0000 + 32'(w * 4), 4'(k), 8'(l), 2, lat);
        for (int j = 0; j <= l; j++) begin
          n_chk++;
          if (rd_buf[j] !== ref_mem[w+j]) begin
            n_fail++;
            $display("FAIL rnd_load%0d_%0d: got %h required %h",
                     k, j, rd_buf[j], ref_mem[w+j]);
          end
        end
      end
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    sel = 0;
    test_reset();
    test_read_basic();
    test_write_strb();
    test_errors();
    sel = 1;
    pulse_reset();
    test_latency_burst();
    test_reset_inflight();
    sel = 2;
    pulse_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
